// File: rtl/mrx_ctrl_if.sv
// IQ sample stream between the RX datapath and mrx_ctrl: the raw input side
// plus the registered, framed capture output side.
interface mrx_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NCAP_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] irx;
    logic [DATA_WIDTH-1:0] qrx;
    logic                  rx_in_valid;
    logic [DATA_WIDTH-1:0] itx_out;
    logic [DATA_WIDTH-1:0] qtx_out;
    logic                  rx_valid;
    logic                  rx_start;
    logic                  rx_tlast;
    logic [NCAP_WIDTH-1:0] samp_idx;

    // Sample source / capture consumer side
    modport master (
        output irx, qrx, rx_in_valid,
        input  itx_out, qtx_out, rx_valid, rx_start, rx_tlast, samp_idx
    );

    // Capture controller side
    modport slave (
        input  irx, qrx, rx_in_valid,
        output itx_out, qtx_out, rx_valid, rx_start, rx_tlast, samp_idx
    );
endinterface

// File: rtl/mrx_ctrl.sv
// Receive sync validator: checks the transmitter's sync pulse length and, on an
// accepted falling edge, opens a fixed-length capture window over the IQ stream.
module mrx_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_BIT       = 0,
    parameter int SYNC_SIG_N     = 8750,
    parameter int SYNC_TOL       = 64,
    parameter int MIN_LOW        = 1024,
    parameter int NCAP_WIDTH     = 24,
    parameter int NCAP           = 40960
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
    mrx_ctrl_if.slave                 rx,
    output logic                      sync_locked,
    output logic                      sync_err,
    output logic [NCAP_WIDTH-1:0]     hi_len
);
    localparam logic [NCAP_WIDTH-1:0] HI_MIN   = NCAP_WIDTH'(2 * SYNC_SIG_N - SYNC_TOL);
    localparam logic [NCAP_WIDTH-1:0] HI_MAX   = NCAP_WIDTH'(2 * SYNC_SIG_N + SYNC_TOL);
    localparam logic [NCAP_WIDTH-1:0] HI_OVF   = NCAP_WIDTH'(2 * SYNC_SIG_N + SYNC_TOL + 1);
    localparam logic [NCAP_WIDTH-1:0] LOW_LAST = NCAP_WIDTH'(MIN_LOW - 1);
    localparam logic [NCAP_WIDTH-1:0] CAP_LAST = NCAP_WIDTH'(NCAP - 1);

    if (longint'(2 * SYNC_SIG_N + SYNC_TOL) >= (longint'(1) << NCAP_WIDTH)) begin : g_bad_width
        $error("mrx_ctrl: 2*SYNC_SIG_N+SYNC_TOL does not fit in NCAP_WIDTH bits");
    end
    if (SYNC_TOL >= 2 * SYNC_SIG_N) begin : g_bad_tol
        $error("mrx_ctrl: SYNC_TOL must be smaller than 2*SYNC_SIG_N");
    end

    typedef enum logic [1:0] {IDLE, ARMED, HIGH, CAPTURE} state_t;

    state_t                r_state;
    logic [NCAP_WIDTH-1:0] r_cnt;
    logic                  r_sync1, r_s, r_s_d;
    logic [DATA_WIDTH-1:0] r_itx_out, r_qtx_out;
    logic                  r_rx_valid, r_rx_start, r_rx_tlast;
    logic [NCAP_WIDTH-1:0] r_samp_idx;
    logic                  r_sync_locked, r_sync_err;
    logic [NCAP_WIDTH-1:0] r_hi_len;

    logic w_rise, w_fall, w_in_tol;
    logic w_gpio_unused;

    assign w_rise        = r_s & ~r_s_d;
    assign w_fall        = ~r_s & r_s_d;
    assign w_in_tol      = (r_cnt >= HI_MIN) && (r_cnt <= HI_MAX);
    assign w_gpio_unused = ^gpio_in;

    always_ff @(posedge clk) begin
        // NOTE: reset clears every register, sample outputs included, so a
        // reset mid-capture leaves all outputs at 0 the following cycle.
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sync1       <= 1'b0;
            r_s           <= 1'b0;
            r_s_d         <= 1'b0;
            r_itx_out     <= '0;
            r_qtx_out     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_start    <= 1'b0;
            r_rx_tlast    <= 1'b0;
            r_samp_idx    <= '0;
            r_sync_locked <= 1'b0;
            r_sync_err    <= 1'b0;
            r_hi_len      <= '0;
        end else begin
            r_sync1       <= gpio_in[SYNC_BIT];
            r_s           <= r_sync1;
            r_s_d         <= r_s;
            r_rx_valid    <= 1'b0;
            r_rx_start    <= 1'b0;
            r_rx_tlast    <= 1'b0;
            r_sync_err    <= 1'b0;
            r_sync_locked <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOW_LAST) begin
                        r_state <= ARMED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_cnt   <= NCAP_WIDTH'(1);
                    end
                end
                HIGH: begin
                    // The fall cycle's count equals the pin high time exactly.
                    if (w_fall) begin
                        r_hi_len <= r_cnt;
                        r_cnt    <= '0;
                        if (w_in_tol) begin
                            r_state       <= CAPTURE;
                            r_sync_locked <= 1'b1;
                        end else begin
                            r_state    <= IDLE;
                            r_sync_err <= 1'b1;
                        end
                    end else if (r_cnt > HI_MAX) begin
                        r_hi_len   <= HI_OVF;
                        r_sync_err <= 1'b1;
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_sync_locked <= 1'b1;
                    if (rx.rx_in_valid) begin
                        r_itx_out  <= rx.irx;
                        r_qtx_out  <= rx.qrx;
                        r_rx_valid <= 1'b1;
                        r_samp_idx <= r_cnt;
                        r_rx_start <= (r_cnt == '0);
                        r_rx_tlast <= (r_cnt == CAP_LAST);
                        if (r_cnt == CAP_LAST) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx.itx_out  = r_itx_out;
    assign rx.qtx_out  = r_qtx_out;
    assign rx.rx_valid = r_rx_valid;
    assign rx.rx_start = r_rx_start;
    assign rx.rx_tlast = r_rx_tlast;
    assign rx.samp_idx = r_samp_idx;
    assign sync_locked = r_sync_locked;
    assign sync_err    = r_sync_err;
    assign hi_len      = r_hi_len;
endmodule

// File: tb/tb_mrx_ctrl.sv
// Scoreboard bench for mrx_ctrl with scaled-down sync and capture lengths;
// expected samples are queued as stimulus is driven and popped as they emerge.
module tb_mrx_ctrl;
    localparam int DW  = 16;
    localparam int GW  = 12;
    localparam int SB  = 3;
    localparam int SN  = 50;    // valid high time 100, accepted 94..106
    localparam int TOL = 6;
    localparam int ML  = 32;
    localparam int NW  = 24;
    localparam int NC  = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [GW-1:0] gpio_in;
    logic          sync_locked, sync_err;
    logic [NW-1:0] hi_len;

    always #5 clk = ~clk;

    mrx_ctrl_if #(.DATA_WIDTH(DW), .NCAP_WIDTH(NW)) rx ();

    mrx_ctrl #(
        .DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .SYNC_BIT(SB), .SYNC_SIG_N(SN),
        .SYNC_TOL(TOL), .MIN_LOW(ML), .NCAP_WIDTH(NW), .NCAP(NC)
    ) dut (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .rx(rx),
        .sync_locked(sync_locked), .sync_err(sync_err), .hi_len(hi_len)
    );

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic [NW-1:0] idx;
        logic          start;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t q_exp[$];
    exp_t e_mon;

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_valid = 0, n_start = 0, n_tlast = 0, n_err = 0;
    logic [DW-1:0] ramp = '0;
    logic last_pin = 1'b0;
    bit exp_accept = 1'b0;
    int cap_wait = -1, cap_left = 0, cap_idx = 0;
    logic prev_tlast = 1'b0;
    logic [NW-1:0] prev_idx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every valid sample must match the head of the scoreboard
    always @(negedge clk) begin
        if (sync_err === 1'b1) n_err++;
        if (prev_tlast) begin
            checks++;
            if (sync_locked !== 1'b0) begin
                errors++;
                $display("FAIL locked_after_tlast got=%b exp=0", sync_locked);
            end
        end
        prev_tlast = (rx.rx_valid === 1'b1) && (rx.rx_tlast === 1'b1);
        if (rx.rx_valid === 1'b1) begin
            n_valid++;
            if (rx.rx_start === 1'b1) n_start++;
            if (rx.rx_tlast === 1'b1) n_tlast++;
            checks++;
            if (q_exp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got idx=%0d i=%h exp=no sample", rx.samp_idx, rx.itx_out);
            end else begin
                e_mon = q_exp.pop_front();
                if ({rx.itx_out, rx.qtx_out, rx.samp_idx, rx.rx_start, rx.rx_tlast, sync_locked} !==
                    {e_mon.i, e_mon.q, e_mon.idx, e_mon.start, e_mon.last, 1'b1}) begin
                    errors++;
                    $display("FAIL sample got i=%h q=%h idx=%0d start=%b last=%b lock=%b exp i=%h q=%h idx=%0d start=%b last=%b lock=1",
                             rx.itx_out, rx.qtx_out, rx.samp_idx, rx.rx_start, rx.rx_tlast, sync_locked,
                             e_mon.i, e_mon.q, e_mon.idx, e_mon.start, e_mon.last);
                end
                checks++;
                if (cyc != e_mon.cyc) begin
                    errors++;
                    $display("FAIL sample_latency idx=%0d got cycle=%0d exp cycle=%0d", e_mon.idx, cyc, e_mon.cyc);
                end
            end
        end else if (sync_locked === 1'b1) begin
            checks++;
            if (rx.samp_idx !== prev_idx) begin
                errors++;
                $display("FAIL idx_hold got=%0d exp=%0d", rx.samp_idx, prev_idx);
            end
        end
        prev_idx = rx.samp_idx;
    end

    // One cycle of stimulus; the capture model opens 3 cycles after an accepted pin fall
    task automatic step(input logic pin, input logic vld, input logic rst);
        exp_t e;
        reset          = rst;
        gpio_in        = GW'($urandom);
        gpio_in[SB]    = pin;
        ramp           = ramp + 1'b1;
        rx.irx         = ramp;
        rx.qrx         = ramp ^ 16'hA5C3;
        rx.rx_in_valid = vld;
        if (rst) begin
            cap_wait = -1;
            cap_left = 0;
        end else begin
            if (cap_wait > 0) begin
                cap_wait--;
                if (cap_wait == 0) begin
                    cap_left = NC;
                    cap_idx  = 0;
                end
            end
            if (cap_left > 0 && vld) begin
                e.i     = rx.irx;
                e.q     = rx.qrx;
                e.idx   = NW'(cap_idx);
                e.start = (cap_idx == 0);
                e.last  = (cap_idx == NC - 1);
                e.cyc   = cyc + 1;
                q_exp.push_back(e);
                cap_idx++;
                cap_left--;
            end
            if (!pin && last_pin && exp_accept) cap_wait = 3;
        end
        last_pin = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int lo, input int hi, input bit accept);
        exp_accept = accept;
        repeat (lo) step(1'b0, 1'b1, 1'b0);
        repeat (hi) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({rx.itx_out, rx.qtx_out, rx.rx_valid, rx.rx_start, rx.rx_tlast, rx.samp_idx,
             sync_locked, sync_err, hi_len} !== '0) begin
            errors++;
            $display("FAIL %s got i=%h q=%h v=%b s=%b l=%b idx=%0d lock=%b err=%b hi=%0d exp all 0",
                     name, rx.itx_out, rx.qtx_out, rx.rx_valid, rx.rx_start, rx.rx_tlast,
                     rx.samp_idx, sync_locked, sync_err, hi_len);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check_outputs_zero("reset_state");
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_capture();
        int v0 = n_valid, s0 = n_start, t0 = n_tlast, e0 = n_err;
        pulse(60, 100, 1'b1);
        run(NC + 10);
        check_int("cap_hi_len", int'(hi_len), 100);
        check_int("cap_errs", n_err - e0, 0);
        check_int("cap_valid_count", n_valid - v0, NC);
        check_int("cap_start_count", n_start - s0, 1);
        check_int("cap_tlast_count", n_tlast - t0, 1);
        check_int("cap_queue_left", q_exp.size(), 0);
        check_int("cap_locked_after", int'(sync_locked), 0);
    endtask

    task automatic test_tolerance();
        int his[4] = '{94, 106, 93, 107};
        bit acc[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            int v0 = n_valid, e0 = n_err;
            pulse(40, his[k], acc[k]);
            run(acc[k] ? NC + 10 : 10);
            check_int($sformatf("tol_hi_len_%0d", his[k]), int'(hi_len), his[k]);
            check_int($sformatf("tol_errs_%0d", his[k]), n_err - e0, acc[k] ? 0 : 1);
            check_int($sformatf("tol_valid_%0d", his[k]), n_valid - v0, acc[k] ? NC : 0);
        end
    endtask

    task automatic test_stuck_high();
        int v0 = n_valid, e0 = n_err;
        pulse(40, 300, 1'b0);
        check_int("stuck_errs", n_err - e0, 1);
        check_int("stuck_hi_len", int'(hi_len), 2 * SN + TOL + 1);
        // Too little low time: the pulse must be ignored without an error
        e0 = n_err;
        pulse(20, 100, 1'b0);
        run(10);
        check_int("short_low_errs", n_err - e0, 0);
        check_int("short_low_hi_len", int'(hi_len), 2 * SN + TOL + 1);
        check_int("short_low_valid", n_valid - v0, 0);
        pulse(40, 100, 1'b1);
        run(NC + 10);
        check_int("recover_valid", n_valid - v0, NC);
        check_int("recover_hi_len", int'(hi_len), 100);
    endtask

    task automatic test_bubbles();
        int v0 = n_valid, s0 = n_start, t0 = n_tlast, e0 = n_err;
        pulse(40, 100, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        exp_accept = 1'b0;
        for (int i = 0; i < 2 * NC; i++)
            step((i >= 10 && i < 40), (i % 3 != 1), 1'b0);
        run(10);
        check_int("bub_valid_count", n_valid - v0, NC);
        check_int("bub_start_count", n_start - s0, 1);
        check_int("bub_tlast_count", n_tlast - t0, 1);
        check_int("bub_errs", n_err - e0, 0);
        check_int("bub_queue_left", q_exp.size(), 0);
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        int v0, s0, t0;
        pulse(40, 100, 1'b1);
        while (cap_idx != 101 && budget < 400) begin
            step(1'b0, 1'b1, 1'b0);
            budget++;
        end
        check_int("rst_reach_idx100", cap_idx, 101);
        t0 = n_tlast;
        step(1'b0, 1'b1, 1'b1);
        check_outputs_zero("rst_mid_outputs");
        step(1'b0, 1'b1, 1'b0);
        check_int("rst_queue_left", q_exp.size(), 0);
        check_int("rst_no_tlast", n_tlast - t0, 0);
        v0 = n_valid; s0 = n_start; t0 = n_tlast;
        pulse(40, 100, 1'b1);
        run(NC + 10);
        check_int("rst_recap_valid", n_valid - v0, NC);
        check_int("rst_recap_start", n_start - s0, 1);
        check_int("rst_recap_tlast", n_tlast - t0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        gpio_in        = '0;
        rx.irx         = '0;
        rx.qrx         = '0;
        rx.rx_in_valid = 1'b0;
        test_reset();
        test_capture();
        test_tolerance();
        test_stuck_high();
        test_bubbles();
        test_reset_mid();
        check_int("final_queue_left", q_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
